// File: rtl/speck_pkg.sv
// rtl/speck_pkg.sv - shared constants, FSM encodings and rotate helpers for SPECK32/64
package speck_pkg;

    localparam int unsigned WORD_W    = 16;
    localparam int unsigned KEY_WORDS = 4;
    localparam int unsigned ROUNDS    = 22;
    localparam int unsigned ALPHA     = 7;
    localparam int unsigned BETA      = 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] KEY  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // Fixed-width right rotate; the doubled word keeps the wrapped bits
    function automatic logic [WORD_W-1:0] ror16(input logic [WORD_W-1:0] v, input int unsigned n);
        logic [2*WORD_W-1:0] t;
        t = {v, v} >> n;
        return t[WORD_W-1:0];
    endfunction

    // Fixed-width left rotate
    function automatic logic [WORD_W-1:0] rol16(input logic [WORD_W-1:0] v, input int unsigned n);
        logic [2*WORD_W-1:0] t;
        t = {v, v} << n;
        return t[2*WORD_W-1:WORD_W];
    endfunction

endpackage

// File: rtl/speck32_round_ctrl_if.sv
// rtl/speck32_round_ctrl_if.sv - request/response handshakes and shared-adder port bundle
interface speck32_round_ctrl_if;
    import speck_pkg::*;

    logic                          in_valid;
    logic                          in_ready;
    logic [WORD_W*KEY_WORDS-1:0]   key;
    logic [2*WORD_W-1:0]           pt;
    logic                          out_valid;
    logic                          out_ready;
    logic [2*WORD_W-1:0]           ct;
    logic [WORD_W-1:0]             add_a;
    logic [WORD_W-1:0]             add_b;
    logic [WORD_W-1:0]             add_sum;

    // The controller side
    modport slave (
        input  in_valid, key, pt, out_ready, add_sum,
        output in_ready, out_valid, ct, add_a, add_b
    );

    // The requester side, which also hosts the external adder
    modport master (
        output in_valid, key, pt, out_ready, add_sum,
        input  in_ready, out_valid, ct, add_a, add_b
    );

endinterface

// File: rtl/speck32_operand_mux.sv
// rtl/speck32_operand_mux.sv - adder operand selection and next-state datapath for one phase
module speck32_operand_mux #(
    parameter int unsigned ALPHA = speck_pkg::ALPHA,
    parameter int unsigned BETA  = speck_pkg::BETA
) (
    input  logic [1:0]  state_i,
    input  logic [4:0]  rnd_i,
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    input  logic [15:0] k_i,
    input  logic [15:0] l0_i,
    input  logic [15:0] add_sum_i,
    output logic [15:0] add_a_o,
    output logic [15:0] add_b_o,
    output logic [15:0] x_nxt_o,
    output logic [15:0] y_nxt_o,
    output logic [15:0] k_nxt_o,
    output logic [15:0] lnew_o
);
    import speck_pkg::*;

    logic [15:0] data_mix;

    // Drive the shared adder only while a phase actually needs it
    always_comb begin
        add_a_o = '0;
        add_b_o = '0;
        case (state_i)
            DATA: begin
                add_a_o = ror16(x_i, ALPHA);
                add_b_o = y_i;
            end
            KEY: begin
                add_a_o = ror16(l0_i, ALPHA);
                add_b_o = k_i;
            end
            default: ;
        endcase
    end

    // Both phases share add_sum; the FSM picks which results it commits
    assign data_mix = add_sum_i ^ k_i;
    assign x_nxt_o  = data_mix;
    assign y_nxt_o  = rol16(y_i, BETA) ^ data_mix;
    assign lnew_o   = add_sum_i ^ {11'b0, rnd_i};
    assign k_nxt_o  = rol16(k_i, BETA) ^ lnew_o;

endmodule

// File: rtl/speck32_round_ctrl.sv
// rtl/speck32_round_ctrl.sv - iterative SPECK32/64 encryptor time-sharing one external adder
module speck32_round_ctrl #(
    parameter int unsigned ROUNDS = speck_pkg::ROUNDS,
    parameter int unsigned ALPHA  = speck_pkg::ALPHA,
    parameter int unsigned BETA   = speck_pkg::BETA
) (
    input  logic                 clk,
    input  logic                 rst,
    speck32_round_ctrl_if.slave  bus
);
    import speck_pkg::*;

    localparam logic [4:0] LAST_RND = 5'(ROUNDS - 1);

    logic [1:0]  state_q, state_d;
    logic [4:0]  rnd_q, rnd_d;
    logic [15:0] x_q, x_d, y_q, y_d, k_q, k_d;
    logic [15:0] l0_q, l0_d, l1_q, l1_d, l2_q, l2_d;
    logic [15:0] x_nxt, y_nxt, k_nxt, lnew;

    speck32_operand_mux #(
        .ALPHA (ALPHA),
        .BETA  (BETA)
    ) u_mux (
        .state_i   (state_q),
        .rnd_i     (rnd_q),
        .x_i       (x_q),
        .y_i       (y_q),
        .k_i       (k_q),
        .l0_i      (l0_q),
        .add_sum_i (bus.add_sum),
        .add_a_o   (bus.add_a),
        .add_b_o   (bus.add_b),
        .x_nxt_o   (x_nxt),
        .y_nxt_o   (y_nxt),
        .k_nxt_o   (k_nxt),
        .lnew_o    (lnew)
    );

    // Sequencing: load in IDLE, alternate DATA/KEY, skip the last key update, hold in DONE
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        x_d     = x_q;
        y_d     = y_q;
        k_d     = k_q;
        l0_d    = l0_q;
        l1_d    = l1_q;
        l2_d    = l2_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d     = bus.pt[31:16];
                    y_d     = bus.pt[15:0];
                    k_d     = bus.key[15:0];
                    l0_d    = bus.key[31:16];
                    l1_d    = bus.key[47:32];
                    l2_d    = bus.key[63:48];
                    rnd_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                x_d     = x_nxt;
                y_d     = y_nxt;
                state_d = (rnd_q == LAST_RND) ? DONE : KEY;
            end
            KEY: begin
                k_d     = k_nxt;
                l0_d    = l1_q;
                l1_d    = l2_q;
                l2_d    = lnew;
                rnd_d   = rnd_q + 5'd1;
                state_d = DATA;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any job in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            k_q     <= '0;
            l0_q    <= '0;
            l1_q    <= '0;
            l2_q    <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            x_q     <= x_d;
            y_q     <= y_d;
            k_q     <= k_d;
            l0_q    <= l0_d;
            l1_q    <= l1_d;
            l2_q    <= l2_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.ct        = {x_q, y_q};

endmodule

// File: tb/tb_speck32_round_ctrl.sv
// tb/tb_speck32_round_ctrl.sv - self-checking bench for speck32_round_ctrl
module tb_speck32_round_ctrl;

    typedef struct {
        logic [63:0] key;
        logic [31:0] pt;
        logic [31:0] exp_ct;
    } vec_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_results = 0;
    int   last_acc = -1;
    int   last_gap = 0;
    bit   rand_ready = 0;
    logic [31:0] exp_q[$];
    vec_t vecs[4];

    speck32_round_ctrl_if bus();

    speck32_round_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.add_sum = bus.add_a + bus.add_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] t_ror(input logic [15:0] v, input int n);
        return (v >> n) | (v << (16 - n));
    endfunction

    function automatic logic [15:0] t_rol(input logic [15:0] v, input int n);
        return (v << n) | (v >> (16 - n));
    endfunction

    // Reference SPECK32/64 with a precomputed-style key schedule array
    function automatic logic [31:0] speck_model(input logic [63:0] key, input logic [31:0] pt);
        logic [15:0] x, y, k;
        logic [15:0] l [0:40];
        x = pt[31:16];
        y = pt[15:0];
        k = key[15:0];
        l[0] = key[31:16];
        l[1] = key[47:32];
        l[2] = key[63:48];
        for (int i = 0; i < 22; i++) begin
            x = (t_ror(x, 7) + y) ^ k;
            y = t_rol(y, 2) ^ x;
            if (i < 21) begin
                l[i+3] = (k + t_ror(l[i], 7)) ^ 16'(i);
                k = t_rol(k, 2) ^ l[i+3];
            end
        end
        return {x, y};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h", name, act, exp);
    endtask

    // Output monitor: pops the scoreboard and tracks the issue interval
    always @(negedge clk) begin
        if (rst) begin
            last_acc = -1;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                if (last_acc >= 0) begin
                    last_gap = cyc - last_acc;
                    check("issue_gap_ge_45", 64'(last_gap >= 45), 64'd1);
                end
                last_acc = cyc;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL ct_unexpected actual=%h expected=no_output", bus.ct);
                end else begin
                    check("ct", 64'(bus.ct), 64'(exp_q.pop_front()));
                    n_results++;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [63:0] k, input logic [31:0] p, input logic [31:0] exp);
        bit ok;
        ok = 0;
        @(posedge clk);
        #1;
        bus.key = k;
        bus.pt = p;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.in_ready && !rst) begin
                ok = 1;
                break;
            end
        end
        if (ok) exp_q.push_back(exp);
        else check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out_valid();
        bit seen;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check("out_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && bus.in_ready) begin
                done = 1;
                break;
            end
        end
        if (!done) check("drain_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        vecs[0] = '{64'h1918_1110_0908_0100, 32'h6574_694C, 32'hA868_42F2};
        vecs[1] = '{64'h0123_4567_89AB_CDEF, 32'hDEAD_BEEF, 32'h0};
        vecs[2] = '{{$urandom, $urandom}, $urandom, 32'h0};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0000, 32'h0};
        for (int i = 1; i < 4; i++) vecs[i].exp_ct = speck_model(vecs[i].key, vecs[i].pt);

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.key = '0;
        bus.pt = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_ct", 64'(bus.ct), 64'd0);
        check("rst_add_a", 64'(bus.add_a), 64'd0);
        check("rst_add_b", 64'(bus.add_b), 64'd0);

        // Known vector: operands of the first two phases and latency
        bus.out_ready = 1'b1;
        send(vecs[0].key, vecs[0].pt, vecs[0].exp_ct);
        e0 = cyc;
        @(negedge clk);
        check("data0_add_a", 64'(bus.add_a), 64'h E8CA);
        check("data0_add_b", 64'(bus.add_b), 64'h694C);
        check("data0_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        check("key0_add_a", 64'(bus.add_a), 64'(t_ror(16'h0908, 7)));
        check("key0_add_b", 64'(bus.add_b), 64'h0100);
        wait_out_valid();
        check("latency", 64'(cyc - e0), 64'd43);
        drain();

        // Output stall
        bus.out_ready = 1'b0;
        send(vecs[0].key, vecs[0].pt, vecs[0].exp_ct);
        wait_out_valid();
        for (int i = 0; i < 10; i++) begin
            check("stall_ct", 64'(bus.ct), 64'hA868_42F2);
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            check("stall_out_valid", 64'(bus.out_valid), 64'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("release_in_ready", 64'(bus.in_ready), 64'd1);
        check("release_out_valid", 64'(bus.out_valid), 64'd0);

        // Busy ignore: second request held from cycle 5 onward
        send(vecs[0].key, vecs[0].pt, vecs[0].exp_ct);
        repeat (3) @(posedge clk);
        send(vecs[1].key, vecs[1].pt, vecs[1].exp_ct);
        check("busy_second_accept_gap", 64'(last_gap), 64'd45);
        drain();

        // Reset mid-job
        send(vecs[0].key, vecs[0].pt, vecs[0].exp_ct);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_add_a", 64'(bus.add_a), 64'd0);
        check("midrst_add_b", 64'(bus.add_b), 64'd0);
        send(vecs[0].key, vecs[0].pt, vecs[0].exp_ct);
        drain();

        // Back-to-back table jobs with random output backpressure
        rand_ready = 1;
        for (int i = 0; i < 4; i++) send(vecs[i].key, vecs[i].pt, vecs[i].exp_ct);
        drain();
        rand_ready = 0;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);

        check("result_count", 64'(n_results), 64'd9);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/speck32_round_ctrl.md
Name: speck32_round_ctrl

Overview:
Iterative SPECK32/64 encryption controller built around one shared external 16-bit ripple adder (the mMIG, MIG or AOIG variant).
- The adder is instantiated outside this block, so logic-style variants can be swapped without touching the controller.
- Each round uses the adder twice, time-multiplexed: a DATA phase (round function) and a KEY phase (on-the-fly key expansion).
- Valid/ready handshakes on the input and output sides.

Parameters:
ROUNDS, 22, number of SPECK32/64 rounds (legal range 2..31)
ALPHA, 7, right-rotate amount applied to x and to l
BETA, 2, left-rotate amount applied to y and to k

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  plaintext/key request valid
in_ready  out  1  block idle and able to accept a request
key  in  64  {l2,l1,l0,k0}, with k0 = key[15:0]
pt  in  32  {x,y}, with x = pt[31:16]
out_valid  out  1  ciphertext valid
out_ready  in  1  consumer accepts ciphertext
ct  out  32  {x,y} after ROUNDS rounds
add_a  out  16  shared adder operand A (combinational from state)
add_b  out  16  shared adder operand B
add_sum  in  16  shared adder result; combinational, same cycle, carry-out discarded (mod 2^16)

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, ct=0, add_a=add_b=0, round counter=0, x/y/k/l registers=0.
- States: IDLE, DATA, KEY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge, load x,y from pt and k,l0,l1,l2 from key; set rnd=0; go to DATA.
- DATA:
  - add_a = ROR_ALPHA(x), add_b = y.
  - Next x = add_sum ^ k; next y = ROL_BETA(y) ^ (add_sum ^ k).
  - If rnd == ROUNDS-1, go to DONE (the final key update is skipped); otherwise go to KEY.
- KEY:
  - add_a = ROR_ALPHA(l0), add_b = k; lnew = add_sum ^ {11'b0, rnd}.
  - Next k = ROL_BETA(k) ^ lnew; shift l0<=l1, l1<=l2, l2<=lnew.
  - rnd <= rnd+1; go to DATA.
- DONE:
  - out_valid=1; ct={x,y} held stable while out_ready=0.
  - On out_ready at an edge, go to IDLE (out_valid=0 on the next cycle).
- Latency:
  - Accept at edge E0; out_valid=1 after edge E0 + 2*ROUNDS-1 (43 cycles for ROUNDS=22).
  - Minimum issue interval is 2*ROUNDS+1 cycles: an IDLE cycle is required between jobs, with no accept in DONE.
- add_a/add_b outside DATA/KEY: 0.
- Busy behaviour: in_ready=0 in DATA/KEY/DONE; in_valid during those states is ignored and the inputs are not sampled.
- Arithmetic width rules:
  - All arithmetic is mod 2^16.
  - The round index XOR uses the 5-bit rnd zero-extended to 16 bits.
  - Rotations are fixed-width 16-bit rotations.
- Reset mid-operation: rst in any state forces all reset values on the next edge; the job is dropped and no out_valid is issued.
- Simultaneous events:
  - rst has priority over in_valid and out_ready.
  - in_valid and out_ready both asserted in DONE: only the output handshake completes; the new request waits for IDLE.

Decomposition:
- Shared package speck_pkg holds:
  - Constants: WORD_W=16, KEY_WORDS=4, ROUNDS=22, ALPHA=7, BETA=2.
  - State enum: IDLE/DATA/KEY/DONE.
  - Rotate functions: ror16, rol16.
- One natural sub-module: speck32_operand_mux. It is combinational; it selects add_a/add_b from state and computes next x/y/k/lnew from add_sum.
- The FSM, counter and registers stay in speck32_round_ctrl.
- The bench and top level connect add_a/add_b/add_sum to any existing 16-bit adder.

Test Plan:
- Known vector: key=64'h1918_1110_0908_0100, pt=32'h6574_694C, out_ready=1 -> ct=32'hA868_42F2; out_valid rises exactly 43 cycles after the accept edge.
- First DATA cycle after that accept -> add_a=16'hE8CA, add_b=16'h694C. First KEY cycle -> add_a=ROR7(16'h0908), add_b=16'h0100.
- Output stall: same vector with out_ready=0 for 10 cycles after out_valid -> ct stable at A868_42F2, in_ready=0 throughout. Raise out_ready -> IDLE next cycle, in_ready=1.
- Busy ignore: assert in_valid with a different key/pt during cycles 5..20 of a job -> first result is still A868_42F2; the second request is accepted only after returning to IDLE.
- Reset mid-job: rst at cycle 20 -> next cycle in_ready=1, out_valid=0, add_a=add_b=0. A fresh known-vector job then yields A868_42F2.
- Back-to-back: 3 queued jobs against a golden model, with randomized out_ready -> all ct values match; issue interval is at least 45 cycles.
